// File: rtl/mem_bus_master_pkg.sv
// Shared constants and state encoding for the Sigma-style memory bus master.
// Words are big-endian numbered: bit 0 is the MSB, byte lane 0 is bits [0:7].
package mem_bus_master_pkg;

  localparam int WORD_BITS = 32;
  localparam int ADDR_BITS = 17;
  localparam int LANES     = 4;
  localparam int BYTE_BITS = WORD_BITS / LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_bus_master_byte_merge.sv
// Combinational byte-lane merge for read-modify-write stores: enabled lanes
// take the new word's byte, disabled lanes keep the old word's byte.
module byte_merge
  import mem_bus_master_pkg::*;
(
  input  logic [0:WORD_BITS-1] i_old_word,
  input  logic [0:WORD_BITS-1] i_new_word,
  input  logic [0:LANES-1]     i_byte_en,
  output logic [0:WORD_BITS-1] o_merged
);

  // NOTE: assigning a full default before any conditional update keeps this
  // block free of inferred latches.
  always_comb begin
    o_merged = i_old_word;
    for (int i = 0; i < LANES; i++) begin
      if (i_byte_en[i]) begin
        o_merged[BYTE_BITS*i +: BYTE_BITS] = i_new_word[BYTE_BITS*i +: BYTE_BITS];
      end
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the single-port word memory: one load or store at a
// time, with read-modify-write for partial stores and a one-cycle response.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int                     ADDR_BITS    = 17,
  parameter int                     WAIT_STATES  = 0,
  parameter logic [32-ADDR_BITS:31] ADDRESS_MASK = 17'h1ffff
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [32-ADDR_BITS:31]   req_address,
  input  logic [0:WORD_BITS-1]     req_wdata,
  input  logic [0:LANES-1]         req_byte_en,
  output logic                     rsp_valid,
  output logic [0:WORD_BITS-1]     rsp_rdata,
  output logic [32-ADDR_BITS:31]   mem_address,
  output logic                     mem_write_en,
  output logic [0:WORD_BITS-1]     mem_data_out,
  input  logic [0:WORD_BITS-1]     mem_data_in
);

  state_e                   r_state;
  state_e                   w_next_state;
  logic                     r_write;
  logic [0:LANES-1]         r_byte_en;
  logic [0:WORD_BITS-1]     r_wdata;
  logic [0:WORD_BITS-1]     r_rdata;
  logic [0:WORD_BITS-1]     r_mem_dout;
  logic [32-ADDR_BITS:31]   r_mem_addr;
  logic [2:0]               r_wait;

  logic                     w_accept;
  logic                     w_full;
  logic                     w_none;
  logic                     w_sample;
  logic [0:WORD_BITS-1]     w_merged;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_full   = &req_byte_en;
  assign w_none   = ~|req_byte_en;
  assign w_sample = (r_state == ST_READ) && (r_wait == 3'd0);

  byte_merge u_byte_merge (
    .i_old_word (mem_data_in),
    .i_new_word (r_wdata),
    .i_byte_en  (r_byte_en),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!req_write)  w_next_state = ST_READ;
          else if (w_none) w_next_state = ST_RESP;
          else if (w_full) w_next_state = ST_WRITE;
          else             w_next_state = ST_READ;
        end
      end
      ST_READ:  if (r_wait == 3'd0) w_next_state = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write    <= 1'b0;
      r_byte_en  <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mem_dout <= '0;
      r_mem_addr <= '0;
      r_wait     <= 3'd0;
    end else begin
      if (w_accept) begin
        r_write   <= req_write;
        r_byte_en <= req_byte_en;
        r_wdata   <= req_wdata;
        r_wait    <= 3'(WAIT_STATES);
        // An empty store never touches memory, so the port keeps its last address.
        if (!req_write || !w_none) r_mem_addr <= req_address & ADDRESS_MASK;
        if (req_write && w_full)   r_mem_dout <= req_wdata;
      end
      if (r_state == ST_READ && r_wait != 3'd0) r_wait <= r_wait - 3'd1;
      if (w_sample) begin
        if (r_write) r_mem_dout <= w_merged;
        else         r_rdata    <= mem_data_in;
      end
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_rdata    = (r_state == ST_RESP && !r_write) ? r_rdata : '0;
  assign mem_address  = r_mem_addr;
  assign mem_write_en = (r_state == ST_WRITE);
  assign mem_data_out = r_mem_dout;

endmodule
